// File: rtl/montacargas_cabina_emulador_pkg.sv
// rtl/montacargas_cabina_emulador_pkg.sv - motor command encodings and floor-window helper
package montacargas_cabina_emulador_pkg;

  // Motor command encodings, shared with the Montacargas controller
  typedef enum logic [1:0] {
    MOTOR_STOP   = 2'b00,
    MOTOR_BAJAR  = 2'b01,
    MOTOR_SUBIR  = 2'b10,
    MOTOR_ILEGAL = 2'b11
  } motor_cmd_e;

  localparam int POS_W = 8;

  // True while pos lies within +/- mitad steps of centro
  function automatic logic en_ventana(input int pos, input int centro, input int mitad);
    int dif;
    dif = pos - centro;
    if (dif < 0) dif = -dif;
    return (dif <= mitad);
  endfunction

endpackage

// File: rtl/montacargas_cabina_emulador_generador_tick.sv
// rtl/montacargas_cabina_emulador_generador_tick.sv - free-running prescaler with one-cycle tick
module montacargas_cabina_emulador_generador_tick #(
  parameter int DIV = 400000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap to zero at terminal count, otherwise count up
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == TERM) cnt_d = '0;
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/montacargas_cabina_emulador.sv
// rtl/montacargas_cabina_emulador.sv - elevator shaft plant model producing floor limit switches
module montacargas_cabina_emulador
  import montacargas_cabina_emulador_pkg::*;
#(
  parameter int CLK_HZ          = 4000000,
  parameter int TICK_HZ         = 10,
  parameter int STEPS_PER_FLOOR = 100,
  parameter int SW_HALF         = 1,
  parameter int INIT_POS        = 0
) (
  input  logic             clockBase_4MHz,
  input  logic             reset,
  input  logic [1:0]       DriverMotor,
  output logic             FinalCarreraPiso1,
  output logic             FinalCarreraPiso2,
  output logic             FinalCarreraPiso3,
  output logic [POS_W-1:0] PosicionCabina,
  output logic             Moviendo,
  output logic             Falla
);

  localparam int               DIV       = CLK_HZ / TICK_HZ;
  localparam int               POS_MAX   = 2 * STEPS_PER_FLOOR;
  localparam logic [POS_W-1:0] POS_MAX_L = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_INI_L = POS_W'(INIT_POS);

  // Parameter sanity: position must fit 8 bits, floor windows must not overlap
  if (POS_MAX > 255) begin : g_chk_pos_max
    $error("POS_MAX exceeds 8-bit position range");
  end
  if (2 * SW_HALF >= STEPS_PER_FLOOR) begin : g_chk_sw_half
    $error("SW_HALF too large: floor windows would overlap");
  end
  if (INIT_POS < 0 || INIT_POS > POS_MAX) begin : g_chk_init_pos
    $error("INIT_POS outside 0..POS_MAX");
  end

  logic             tick;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             falla_q, falla_d;
  logic             moviendo_q, moviendo_d;
  logic [2:0]       fc_q, fc_d, fc_ini;
  motor_cmd_e       cmd;

  montacargas_cabina_emulador_generador_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk_i  (clockBase_4MHz),
    .rst_i  (reset),
    .tick_o (tick)
  );

  assign cmd = motor_cmd_e'(DriverMotor);

  // Position stepping, end-stop saturation and sticky fault detection
  always_comb begin
    pos_d      = pos_q;
    falla_d    = falla_q;
    moviendo_d = 1'b0;
    case (cmd)
      MOTOR_SUBIR: begin
        moviendo_d = (pos_q < POS_MAX_L);
        if (tick) begin
          if (pos_q < POS_MAX_L) pos_d   = pos_q + POS_W'(1);
          else                   falla_d = 1'b1;
        end
      end
      MOTOR_BAJAR: begin
        moviendo_d = (pos_q != '0);
        if (tick) begin
          if (pos_q != '0) pos_d   = pos_q - POS_W'(1);
          else             falla_d = 1'b1;
        end
      end
      MOTOR_ILEGAL: falla_d = 1'b1;
      default: ;
    endcase
  end

  // Floor-window comparators against the current and the reset position
  always_comb begin
    fc_d   = '0;
    fc_ini = '0;
    for (int n = 0; n < 3; n++) begin
      fc_d[n]   = en_ventana(int'(pos_q), n * STEPS_PER_FLOOR, SW_HALF);
      fc_ini[n] = en_ventana(INIT_POS, n * STEPS_PER_FLOOR, SW_HALF);
    end
  end

  // State registers; reset reloads the initial position and its switch pattern
  always_ff @(posedge clockBase_4MHz) begin
    if (reset) begin
      pos_q      <= POS_INI_L;
      falla_q    <= 1'b0;
      moviendo_q <= 1'b0;
      fc_q       <= fc_ini;
    end else begin
      pos_q      <= pos_d;
      falla_q    <= falla_d;
      moviendo_q <= moviendo_d;
      fc_q       <= fc_d;
    end
  end

  assign PosicionCabina    = pos_q;
  assign Falla             = falla_q;
  assign Moviendo          = moviendo_q;
  assign FinalCarreraPiso1 = fc_q[0];
  assign FinalCarreraPiso2 = fc_q[1];
  assign FinalCarreraPiso3 = fc_q[2];

endmodule
